// File: rtl/ttl_pkg.sv
// Shared op-codes and per-channel state encoding for the TTL output bank.
package ttl_pkg;

  // Host operation codes carried on CMD_OP.
  typedef enum logic [1:0] {
    OP_PULSE  = 2'b00,
    OP_TOGGLE = 2'b01,
    OP_SET    = 2'b10,
    OP_CLEAR  = 2'b11
  } op_e;

  // Per-channel output state; the logical level is high in ST_HIGH and ST_PULSE.
  typedef enum logic [1:0] {
    ST_LOW   = 2'b00,
    ST_HIGH  = 2'b01,
    ST_PULSE = 2'b10
  } state_e;

endpackage

// File: rtl/ttl_channel.sv
// One TTL channel: LOW/HIGH/PULSE state machine with a programmable pulse down-counter.
module ttl_channel
  import ttl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             accept,
  input  logic [1:0]       op,
  input  logic             en,
  input  logic [LEN_W-1:0] pulse_len,
  output logic             level,
  output logic             busy
);

  state_e           state, state_nxt;
  logic [LEN_W-1:0] count, count_nxt;

  // Next state: an accepted command always wins over a pulse expiring on the same edge.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_nxt = state;
    count_nxt = count;
    if (accept && en) begin
      count_nxt = '0;
      case (op_e'(op))
        OP_PULSE: begin
          // Length 0 is treated as 1; the counter holds remaining high cycles minus one.
          state_nxt = ST_PULSE;
          count_nxt = (pulse_len == '0) ? '0 : pulse_len - LEN_W'(1);
        end
        // A cancelled pulse counts as level 1, so toggling it lands at LOW.
        OP_TOGGLE: state_nxt = (state == ST_LOW) ? ST_HIGH : ST_LOW;
        OP_SET:    state_nxt = ST_HIGH;
        OP_CLEAR:  state_nxt = ST_LOW;
        default:   state_nxt = state;
      endcase
    end else if (state == ST_PULSE) begin
      // Counter only moves while non-zero, so it can never wrap.
      if (count == '0) state_nxt = ST_LOW;
      else             count_nxt = count - LEN_W'(1);
    end
  end

  // State and counter registers; reset aborts any pulse in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state <= ST_LOW;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  assign level = (state != ST_LOW);
  assign busy  = (state == ST_PULSE);

endmodule

// File: rtl/ttl_output_bank.sv
// N-channel TTL output driver: host instruction latch, per-channel FSMs, pin polarity.
module ttl_output_bank
  import ttl_pkg::*;
#(
  parameter int                NUM_CH     = 2,
  parameter int                LEN_W      = 16,
  parameter logic [NUM_CH-1:0] OUT_INVERT = '0
) (
  input  logic              FX2_Clk,
  input  logic              FX2_Rst_n,
  input  logic              CMD_VALID,
  input  logic [1:0]        CMD_OP,
  input  logic [NUM_CH-1:0] CMD_MASK,
  input  logic [LEN_W-1:0]  PULSE_LEN,
  output logic              CMD_ACK,
  output logic [NUM_CH-1:0] TTLOUTPUTS,
  output logic [NUM_CH-1:0] BUSY
);

  logic              accept;
  logic [NUM_CH-1:0] level;

  // One action per host strobe: accept only on the rising edge of the held level.
  assign accept = CMD_VALID && !CMD_ACK;

  // Instruction latch: set on acceptance, released once the host drops CMD_VALID.
  always_ff @(posedge FX2_Clk or negedge FX2_Rst_n) begin
    if (!FX2_Rst_n)      CMD_ACK <= 1'b0;
    else if (accept)     CMD_ACK <= 1'b1;
    else if (!CMD_VALID) CMD_ACK <= 1'b0;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    ttl_channel #(
      .LEN_W(LEN_W)
    ) u_ch (
      .clk      (FX2_Clk),
      .rst_n    (FX2_Rst_n),
      .accept   (accept),
      .op       (CMD_OP),
      .en       (CMD_MASK[i]),
      .pulse_len(PULSE_LEN),
      .level    (level[i]),
      .busy     (BUSY[i])
    );
  end

  // Levels come straight from channel state registers; polarity is a constant XOR.
  assign TTLOUTPUTS = level ^ OUT_INVERT;

endmodule

// File: tb/tb_ttl_output_bank.sv
// Randomised and directed bench for ttl_output_bank against a remaining-high-time model.
module tb_ttl_output_bank;
  localparam int         NUM_CH = 2;
  localparam int         LEN_W  = 16;
  localparam logic [1:0] INV    = 2'b10;

  logic              FX2_Clk   = 1'b0;
  logic              FX2_Rst_n = 1'b0;
  logic              CMD_VALID = 1'b0;
  logic [1:0]        CMD_OP    = 2'b00;
  logic [NUM_CH-1:0] CMD_MASK  = '0;
  logic [LEN_W-1:0]  PULSE_LEN = '0;
  logic              CMD_ACK;
  logic [NUM_CH-1:0] TTLOUTPUTS;
  logic [NUM_CH-1:0] BUSY;

  int n_assert = 0;
  int n_fail   = 0;

  // Model: host handshake bit, logical levels, and remaining high cycles of a pulse.
  bit         m_ack;
  bit [1:0]   m_lvl;
  int         m_rem [NUM_CH];

  ttl_output_bank #(
    .NUM_CH(NUM_CH), .LEN_W(LEN_W), .OUT_INVERT(INV)
  ) dut (
    .FX2_Clk   (FX2_Clk),
    .FX2_Rst_n (FX2_Rst_n),
    .CMD_VALID (CMD_VALID),
    .CMD_OP    (CMD_OP),
    .CMD_MASK  (CMD_MASK),
    .PULSE_LEN (PULSE_LEN),
    .CMD_ACK   (CMD_ACK),
    .TTLOUTPUTS(TTLOUTPUTS),
    .BUSY      (BUSY)
  );

  always #5 FX2_Clk = ~FX2_Clk;

  function automatic logic [4:0] expv();
    logic [1:0] b;
    for (int i = 0; i < NUM_CH; i++) b[i] = (m_rem[i] > 0);
    return {m_ack, b, m_lvl ^ INV};
  endfunction

  function automatic logic [4:0] obsv();
    return {CMD_ACK, BUSY, TTLOUTPUTS};
  endfunction

  task automatic model_reset();
    m_ack = 0;
    m_lvl = '0;
    for (int i = 0; i < NUM_CH; i++) m_rem[i] = 0;
  endtask

  task automatic drive(input bit v, input bit [1:0] op, input bit [1:0] mask, input bit [15:0] len);
    CMD_VALID = v;
    CMD_OP    = op;
    CMD_MASK  = mask;
    PULSE_LEN = len;
  endtask

  // Advance one clock and apply the behavioural rules to the model; returns 1 ns after the edge.
  task automatic tick();
    bit acc;
    @(posedge FX2_Clk);
    acc = CMD_VALID && !m_ack;
    for (int i = 0; i < NUM_CH; i++) begin
      if (acc && CMD_MASK[i]) begin
        case (CMD_OP)
          2'b00: begin m_lvl[i] = 1; m_rem[i] = (PULSE_LEN == 0) ? 1 : int'(PULSE_LEN); end
          2'b01: begin
            if (m_rem[i] > 0) begin m_lvl[i] = 0; m_rem[i] = 0; end
            else m_lvl[i] = ~m_lvl[i];
          end
          2'b10: begin m_lvl[i] = 1; m_rem[i] = 0; end
          default: begin m_lvl[i] = 0; m_rem[i] = 0; end
        endcase
      end else if (m_rem[i] > 0) begin
        m_rem[i]--;
        if (m_rem[i] == 0) m_lvl[i] = 0;
      end
    end
    if (acc) m_ack = 1;
    else if (!CMD_VALID) m_ack = 0;
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    n_assert++;
    if ({CMD_ACK, BUSY, TTLOUTPUTS} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_state: got %b want %b", {CMD_ACK, BUSY, TTLOUTPUTS}, 5'b00010);
    end
    @(negedge FX2_Clk);
    FX2_Rst_n = 1'b1;
  endtask

  task automatic test_pulse_held();
    int hi;
    for (int s = 0; s < 2; s++) begin
      hi = 0;
      drive(1, 2'b00, 2'b01, 16'd5);
      for (int c = 0; c < 20; c++) begin
        tick();
        if (TTLOUTPUTS[0]) hi++;
        n_assert++;
        if (obsv() !== expv()) begin
          n_fail++;
          $display("FAIL pulse_held s%0d c%0d: got %b want %b", s, c, obsv(), expv());
        end
      end
      drive(0, 2'b00, 2'b00, 16'd0);
      tick();
      n_assert++;
      if (CMD_ACK !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_release s%0d: got %b want 0", s, CMD_ACK);
      end
      n_assert++;
      if (hi != 5) begin
        n_fail++;
        $display("FAIL pulse5_width s%0d: got %0d want 5", s, hi);
      end
    end
  endtask

  task automatic test_pulse_lengths();
    int hi;
    for (int k = 0; k < 2; k++) begin
      hi = 0;
      drive(1, 2'b00, 2'b01, 16'(k));
      for (int c = 0; c < 6; c++) begin
        tick();
        if (c == 0) drive(0, 2'b00, 2'b00, 16'd0);
        if (TTLOUTPUTS[0]) hi++;
        n_assert++;
        if (obsv() !== expv()) begin
          n_fail++;
          $display("FAIL pulse_len%0d c%0d: got %b want %b", k, c, obsv(), expv());
        end
      end
      n_assert++;
      if (hi != 1) begin
        n_fail++;
        $display("FAIL pulse_len%0d_width: got %0d want 1", k, hi);
      end
    end
  endtask

  task automatic test_long_pulse();
    int hi = 0;
    int bad = 0;
    drive(1, 2'b00, 2'b01, 16'hFFFF);
    for (int c = 0; c < 65540; c++) begin
      tick();
      if (c == 0) drive(0, 2'b00, 2'b00, 16'd0);
      if (TTLOUTPUTS[0]) hi++;
      if (obsv() !== expv()) bad++;
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL long_pulse_trace: got %0d differing cycles want 0", bad);
    end
    n_assert++;
    if (hi != 65535 || BUSY !== 2'b00) begin
      n_fail++;
      $display("FAIL long_pulse_width: got %0d busy %b want 65535 busy 00", hi, BUSY);
    end
  endtask

  task automatic test_toggle();
    logic [1:0] want;
    for (int s = 0; s < 2; s++) begin
      want = (s == 0) ? 2'b01 : 2'b10;
      drive(1, 2'b01, 2'b11, 16'd0);
      for (int c = 0; c < 10; c++) begin
        tick();
        n_assert++;
        if (obsv() !== expv()) begin
          n_fail++;
          $display("FAIL toggle s%0d c%0d: got %b want %b", s, c, obsv(), expv());
        end
      end
      n_assert++;
      if (TTLOUTPUTS !== want) begin
        n_fail++;
        $display("FAIL toggle_once s%0d: got %b want %b", s, TTLOUTPUTS, want);
      end
      drive(0, 2'b00, 2'b00, 16'd0);
      tick();
    end
  endtask

  task automatic test_retrigger();
    int hi = 0;
    for (int c = 0; c < 15; c++) begin
      if (c == 0)      drive(1, 2'b00, 2'b01, 16'd10);
      else if (c == 4) drive(1, 2'b00, 2'b01, 16'd3);
      else             drive(0, 2'b00, 2'b00, 16'd0);
      tick();
      if (TTLOUTPUTS[0]) hi++;
      n_assert++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL retrigger c%0d: got %b want %b", c, obsv(), expv());
      end
    end
    n_assert++;
    if (hi != 7) begin
      n_fail++;
      $display("FAIL retrigger_width: got %0d want 7", hi);
    end
    // Toggle during a pulse cancels it straight to LOW.
    drive(1, 2'b00, 2'b01, 16'd10);
    tick();
    drive(0, 2'b00, 2'b00, 16'd0);
    tick();
    tick();
    drive(1, 2'b01, 2'b01, 16'd0);
    tick();
    n_assert++;
    if (TTLOUTPUTS[0] !== 1'b0 || BUSY[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_cancel: got out %b busy %b want 0 0", TTLOUTPUTS[0], BUSY[0]);
    end
    drive(0, 2'b00, 2'b00, 16'd0);
    tick();
  endtask

  task automatic test_set_then_pulse();
    int hi = 0;
    drive(1, 2'b10, 2'b10, 16'd0);
    tick();
    n_assert++;
    if (TTLOUTPUTS[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL set_ch1: got pin %b want 0", TTLOUTPUTS[1]);
    end
    drive(0, 2'b00, 2'b00, 16'd0);
    tick();
    drive(1, 2'b00, 2'b10, 16'd2);
    for (int c = 0; c < 6; c++) begin
      tick();
      if (c == 0) drive(0, 2'b00, 2'b00, 16'd0);
      if (!TTLOUTPUTS[1]) hi++;
      n_assert++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL set_pulse c%0d: got %b want %b", c, obsv(), expv());
      end
    end
    n_assert++;
    if (hi != 2 || TTLOUTPUTS[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL set_pulse_end: got width %0d pin %b want 2 1", hi, TTLOUTPUTS[1]);
    end
  endtask

  task automatic test_clear_on_expiry();
    drive(1, 2'b10, 2'b10, 16'd0);
    tick();
    drive(0, 2'b00, 2'b00, 16'd0);
    tick();
    drive(1, 2'b00, 2'b01, 16'd3);
    tick();
    drive(0, 2'b00, 2'b00, 16'd0);
    tick();
    tick();
    n_assert++;
    if (TTLOUTPUTS !== 2'b01 || BUSY !== 2'b01) begin
      n_fail++;
      $display("FAIL pre_expiry: got out %b busy %b want 01 01", TTLOUTPUTS, BUSY);
    end
    drive(1, 2'b11, 2'b11, 16'd0);
    tick();
    n_assert++;
    if ({BUSY, TTLOUTPUTS} !== 4'b0010) begin
      n_fail++;
      $display("FAIL clear_on_expiry: got %b want 0010", {BUSY, TTLOUTPUTS});
    end
    drive(0, 2'b00, 2'b00, 16'd0);
    tick();
  endtask

  task automatic test_mask_zero();
    logic [1:0] snap;
    drive(1, 2'b10, 2'b11, 16'd0);
    tick();
    drive(0, 2'b00, 2'b00, 16'd0);
    tick();
    snap = TTLOUTPUTS;
    drive(1, 2'b11, 2'b00, 16'd0);
    tick();
    n_assert++;
    if (CMD_ACK !== 1'b1 || TTLOUTPUTS !== snap) begin
      n_fail++;
      $display("FAIL mask_zero: got ack %b out %b want 1 %b", CMD_ACK, TTLOUTPUTS, snap);
    end
    drive(0, 2'b00, 2'b00, 16'd0);
    tick();
    n_assert++;
    if (CMD_ACK !== 1'b0 || TTLOUTPUTS !== snap) begin
      n_fail++;
      $display("FAIL mask_zero_release: got ack %b out %b want 0 %b", CMD_ACK, TTLOUTPUTS, snap);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(0, 2) != 0, 2'($urandom), 2'($urandom), 16'($urandom_range(0, 6)));
      tick();
      n_assert++;
      if (obsv() !== expv()) begin
        n_fail++;
        $display("FAIL random c%0d: got %b want %b", c, obsv(), expv());
      end
    end
    drive(0, 2'b00, 2'b00, 16'd0);
    tick();
  endtask

  task automatic test_reset_mid_pulse();
    drive(1, 2'b00, 2'b01, 16'd20);
    tick();
    drive(0, 2'b00, 2'b00, 16'd0);
    tick();
    tick();
    #1;
    FX2_Rst_n = 1'b0;
    #1;
    n_assert++;
    if ({CMD_ACK, BUSY, TTLOUTPUTS} !== 5'b00010) begin
      n_fail++;
      $display("FAIL reset_mid_pulse: got %b want 00010", {CMD_ACK, BUSY, TTLOUTPUTS});
    end
    model_reset();
    @(negedge FX2_Clk);
    FX2_Rst_n = 1'b1;
    for (int c = 0; c < 3; c++) tick();
    n_assert++;
    if (obsv() !== expv()) begin
      n_fail++;
      $display("FAIL post_reset: got %b want %b", obsv(), expv());
    end
  endtask

  initial begin
    test_reset();
    test_pulse_held();
    test_pulse_lengths();
    test_toggle();
    test_retrigger();
    test_set_then_pulse();
    test_clear_on_expiry();
    test_mask_zero();
    test_random();
    test_long_pulse();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ttl_output_bank.md
Name: ttl_output_bank

Overview:
- Parametrised N-channel TTL output driver. It replaces the fixed 2-channel pulse/toggle output logic.
- Host instructions arrive from the FX2 interface as a held-level command. Each command acts on a channel mask and supports pulse, toggle, set and clear operations.
- Pulse length is programmable in clock cycles rather than fixed at one cycle.
- Sits between the FX2 instruction decoder and the board TTL output pins.

Parameters:
- NUM_CH, 2, number of TTL output channels (1..16).
- LEN_W, 16, width of the pulse-length field and the per-channel down-counter.
- OUT_INVERT, 0 (NUM_CH bits), per-channel pin polarity; pin = logical level XOR OUT_INVERT[i].

Ports:
- FX2_Clk  input  1  system clock; all state updates on its rising edge.
- FX2_Rst_n  input  1  asynchronous active-low reset.
- CMD_VALID  input  1  level command strobe from the host; held high until the host sees CMD_ACK.
- CMD_OP  input  2  operation: 00 PULSE, 01 TOGGLE, 10 SET, 11 CLEAR.
- CMD_MASK  input  NUM_CH  channels the command applies to.
- PULSE_LEN  input  LEN_W  pulse high time in cycles; sampled only on command acceptance.
- CMD_ACK  output  1  high while the accepted command is latched (instruction latch).
- TTLOUTPUTS  output  NUM_CH  registered pin outputs.
- BUSY  output  NUM_CH  channel i is currently inside a pulse.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - logical level = 0, so TTLOUTPUTS = OUT_INVERT.
  - BUSY = 0, CMD_ACK = 0, all counters = 0.
  - Reset mid-pulse aborts the pulse immediately.
- Instruction latch:
  - A command is accepted on the first rising FX2_Clk edge where CMD_VALID=1 and CMD_ACK=0.
  - On that edge CMD_ACK<=1.
  - CMD_ACK clears on the first edge where CMD_VALID=0.
  - While CMD_ACK=1 and CMD_VALID=1, no further command is accepted: exactly one action per host strobe, no repeat toggling.
  - CMD_OP, CMD_MASK and PULSE_LEN are sampled only on the acceptance edge.
- Latency: outputs reflect an accepted command on the same acceptance edge, i.e. visible one cycle after CMD_VALID is sampled.
- Per-channel FSM, states LOW, HIGH, PULSE. Transitions on acceptance with mask bit set:
  - PULSE: any state -> PULSE, level=1, counter <= max(PULSE_LEN,1)-1, BUSY=1.
  - TOGGLE: LOW->HIGH, HIGH->LOW. From PULSE -> LOW (pulse cancelled, treated as toggling level 1).
  - SET: -> HIGH. CLEAR: -> LOW. Both cancel an active pulse.
- Channels with mask bit 0 are unaffected.
- In PULSE with no new command:
  - if counter==0, next state LOW, level=0, BUSY=0;
  - else counter decrements.
  - Result: level is high for exactly max(PULSE_LEN,1) cycles.
  - A pulse always ends at LOW, even if the channel was HIGH before the pulse.
- Simultaneous events:
  - A command accepted on the same edge a pulse would expire takes priority over the expiry.
  - PULSE issued to a channel already in PULSE retriggers: the counter reloads with the new length.
- Mask 0 with CMD_VALID still performs the handshake (CMD_ACK asserts) but changes no channel.
- Counter never wraps: it decrements only while non-zero in PULSE.
- TTLOUTPUTS and BUSY are registered; no combinational path from inputs to outputs.

Decomposition:
- Package ttl_pkg:
  - op-code constants OP_PULSE=2'b00, OP_TOGGLE=2'b01, OP_SET=2'b10, OP_CLEAR=2'b11;
  - channel state encoding ST_LOW, ST_HIGH, ST_PULSE.
- Sub-module ttl_channel, one instance per channel:
  - inputs: clock, reset, accept strobe, op, enable bit, pulse length;
  - outputs: level, busy.
- Top level holds the instruction latch, the generate loop over channels, and the polarity XOR.

Test Plan:
- Reset with NUM_CH=2, OUT_INVERT=2'b10 -> TTLOUTPUTS=2'b10, BUSY=0, CMD_ACK=0. Assert FX2_Rst_n=0 mid-pulse -> output returns to 2'b10 without waiting for a clock edge.
- PULSE, mask=01, PULSE_LEN=5, CMD_VALID held 20 cycles -> TTLOUTPUTS[0] high exactly 5 cycles, single pulse only. CMD_ACK high until CMD_VALID drops; second strobe gives a second pulse.
- PULSE_LEN=0 and PULSE_LEN=1 -> each gives a 1-cycle pulse. PULSE_LEN=16'hFFFF -> 65535 cycles, no wrap.
- TOGGLE mask=11 with CMD_VALID held 10 cycles -> both outputs flip once. Second strobe -> flip back.
- PULSE len 10 on ch0, then after 4 cycles PULSE len 3 -> total high time 4+3=7 cycles. TOGGLE during a pulse -> LOW next cycle, BUSY=0.
- SET ch1, then PULSE ch1 len 2 -> high for 2 cycles then LOW. CLEAR accepted on the expiry cycle of another pulse -> LOW, no glitch. Mask=0 strobe -> CMD_ACK handshake, outputs unchanged.
